// File: rtl/pipeline_ctrl_pkg.sv
// rtl/pipeline_ctrl_pkg.sv - shared pipeline control types and constants
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam logic [15:0] NOP_INST_DEFAULT = 16'h0000;

    // Opcode field values shared with the hazard detection unit
    localparam logic [3:0] ALU_OP    = 4'b0000;
    localparam logic [3:0] LOAD_OP   = 4'b0100;
    localparam logic [3:0] STORE_OP  = 4'b0101;
    localparam logic [3:0] BRANCH_OP = 4'b1011;

    localparam logic STALL_ACTIVE = 1'b0;

endpackage

// File: rtl/sat_counter_component.sv
// rtl/sat_counter_component.sv - 8-bit saturating counter with enable and synchronous clear
module sat_counter_component (
    input  logic       i_clk,
    input  logic       i_clr,
    input  logic       i_en,
    output logic [7:0] o_count
);

    logic [7:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_count <= 8'd0;
        end else if (i_en && (r_count != 8'hFF)) begin
            r_count <= r_count + 8'd1;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/ifid_hazard_response_component.sv
// rtl/ifid_hazard_response_component.sv - IF/ID register with stall/flush response
// Optional perf counters: HAZARD_PERF_COUNTERS_EN
module ifid_hazard_response_component
    import pipeline_ctrl_pkg::*;
#(
    parameter int                    DATA_WIDTH   = 16,
    parameter logic [DATA_WIDTH-1:0] NOP_INST     = DATA_WIDTH'(NOP_INST_DEFAULT),
    parameter int                    FLUSH_CYCLES = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  flush,
    input  logic [DATA_WIDTH-1:0] pc_in,
    input  logic [DATA_WIDTH-1:0] inst_in,
    output logic [DATA_WIDTH-1:0] pc_out,
    output logic [DATA_WIDTH-1:0] inst_out,
    output logic                  valid_out,
    output logic                  pc_write,
    output logic                  ifid_write,
    output logic                  bubble,
    output logic [7:0]            stall_count,
    output logic [7:0]            flush_count
);

    generate
        if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 7) begin : g_bad_flush_cycles
            $error("FLUSH_CYCLES must be in 1..7");
        end
    endgenerate

    localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);

    state_t                r_state;
    state_t                w_next_state;
    logic [2:0]            r_flush_cnt;
    logic [2:0]            w_next_cnt;
    logic                  w_stall_req;
    logic                  w_squash_tail;
    logic                  w_squash;
    logic                  w_stall_hold;
    logic [DATA_WIDTH-1:0] r_pc;
    logic [DATA_WIDTH-1:0] r_inst;
    logic                  r_valid;

    assign w_stall_req   = (stall == STALL_ACTIVE);
    // Remaining squash cycles after the initial flush cycle; stall is ignored here
    assign w_squash_tail = (r_state == FLUSH) && (r_flush_cnt != 3'd0);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= RUN;
            r_flush_cnt <= 3'd0;
        end else begin
            r_state     <= w_next_state;
            r_flush_cnt <= w_next_cnt;
        end
    end

    always_comb begin
        w_next_state = RUN;
        w_next_cnt   = 3'd0;
        if (flush) begin
            w_next_state = FLUSH;
            w_next_cnt   = FLUSH_RELOAD;
        end else if (w_squash_tail) begin
            w_next_state = FLUSH;
            w_next_cnt   = r_flush_cnt - 3'd1;
        end else if (w_stall_req) begin
            w_next_state = STALL;
        end
    end

    always_comb begin
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        bubble       = 1'b0;
        w_squash     = 1'b0;
        w_stall_hold = 1'b0;
        if (flush || w_squash_tail) begin
            bubble   = 1'b1;
            w_squash = 1'b1;
        end else if (w_stall_req) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            bubble       = 1'b1;
            w_stall_hold = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_pc    <= '0;
            r_inst  <= NOP_INST;
            r_valid <= 1'b0;
        end else if (ifid_write) begin
            r_pc    <= pc_in;
            r_inst  <= w_squash ? NOP_INST : inst_in;
            r_valid <= ~w_squash;
        end
    end

    assign pc_out    = r_pc;
    assign inst_out  = r_inst;
    assign valid_out = r_valid;

`ifdef HAZARD_PERF_COUNTERS_EN
    sat_counter_component u_stall_counter (
        .i_clk   (clock),
        .i_clr   (reset),
        .i_en    (w_stall_hold),
        .o_count (stall_count)
    );

    sat_counter_component u_flush_counter (
        .i_clk   (clock),
        .i_clr   (reset),
        .i_en    (flush),
        .o_count (flush_count)
    );
`else
    logic w_unused_stall_hold;
    assign w_unused_stall_hold = w_stall_hold;
    assign stall_count = 8'd0;
    assign flush_count = 8'd0;
`endif

endmodule

// File: tb/tb_ifid_hazard_response_component.sv
// tb/tb_ifid_hazard_response_component.sv - scoreboard bench for ifid_hazard_response_component
module tb_ifid_hazard_response_component;

    typedef struct {
        logic [15:0] pc;
        logic [15:0] inst;
        logic        valid;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b1;
    logic        flush = 1'b0;
    logic [15:0] pc_in = 16'h0;
    logic [15:0] inst_in = 16'h0;
    logic [15:0] pc_out;
    logic [15:0] inst_out;
    logic        valid_out;
    logic        pc_write;
    logic        ifid_write;
    logic        bubble;
    logic [7:0]  stall_count;
    logic [7:0]  flush_count;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    ifid_hazard_response_component #(
        .DATA_WIDTH   (16),
        .NOP_INST     (16'h0000),
        .FLUSH_CYCLES (2)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .stall       (stall),
        .flush       (flush),
        .pc_in       (pc_in),
        .inst_in     (inst_in),
        .pc_out      (pc_out),
        .inst_out    (inst_out),
        .valid_out   (valid_out),
        .pc_write    (pc_write),
        .ifid_write  (ifid_write),
        .bubble      (bubble),
        .stall_count (stall_count),
        .flush_count (flush_count)
    );

    always #5 clock = ~clock;

    // Drive one cycle of stimulus and queue the IF/ID contents expected after the edge
    task automatic drive(input logic s, input logic f, input logic [15:0] pc, input logic [15:0] inst,
                         input logic [15:0] e_pc, input logic [15:0] e_inst, input logic e_v);
        exp_t e;
        @(negedge clock);
        stall   = s;
        flush   = f;
        pc_in   = pc;
        inst_in = inst;
        e.pc = e_pc; e.inst = e_inst; e.valid = e_v;
        exp_q.push_back(e);
        #1;
    endtask

    task automatic commit(input string nm);
        exp_t e;
        @(posedge clock);
        #1;
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: scoreboard empty", nm);
        end else begin
            e = exp_q.pop_front();
            if ({pc_out, inst_out, valid_out} !== {e.pc, e.inst, e.valid}) begin
                n_fail++;
                $display("FAIL %s: got pc=%h inst=%h v=%b, want pc=%h inst=%h v=%b",
                         nm, pc_out, inst_out, valid_out, e.pc, e.inst, e.valid);
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clock);
        reset = 1'b1; stall = 1'b0; flush = 1'b1;
        @(posedge clock); #1;
        n_tests++;
        if ({pc_out, inst_out, valid_out, stall_count, flush_count} !== {16'h0, 16'h0, 1'b0, 8'd0, 8'd0}) begin
            n_fail++;
            $display("FAIL reset: got pc=%h inst=%h v=%b sc=%0d fc=%0d, want 0/0/0/0/0",
                     pc_out, inst_out, valid_out, stall_count, flush_count);
        end
        @(negedge clock);
        reset = 1'b0; stall = 1'b1; flush = 1'b0;
    endtask

    task automatic test_run();
        drive(1'b1, 1'b0, 16'h0010, 16'h1234, 16'h0010, 16'h1234, 1'b1);
        n_tests++;
        if ({pc_write, ifid_write, bubble} !== 3'b110) begin
            n_fail++;
            $display("FAIL run_ctrl: got pw/iw/bub=%b%b%b, want 110", pc_write, ifid_write, bubble);
        end
        commit("run_load");
    endtask

    task automatic test_stall();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b0, 16'h0012, 16'h5678, 16'h0010, 16'h1234, 1'b1);
            n_tests++;
            if ({pc_write, ifid_write, bubble} !== 3'b001) begin
                n_fail++;
                $display("FAIL stall_ctrl[%0d]: got pw/iw/bub=%b%b%b, want 001", i, pc_write, ifid_write, bubble);
            end
            commit("stall_hold");
        end
        drive(1'b1, 1'b0, 16'h0012, 16'h5678, 16'h0012, 16'h5678, 1'b1);
        commit("stall_release");
    endtask

    task automatic test_flush();
        drive(1'b1, 1'b1, 16'h0040, 16'hAAAA, 16'h0040, 16'h0000, 1'b0);
        n_tests++;
        if ({pc_write, ifid_write, bubble} !== 3'b111) begin
            n_fail++;
            $display("FAIL flush_ctrl: got pw/iw/bub=%b%b%b, want 111", pc_write, ifid_write, bubble);
        end
        commit("flush_squash1");
        // Stall is ignored on the second squash cycle
        drive(1'b0, 1'b0, 16'h0042, 16'hBBBB, 16'h0042, 16'h0000, 1'b0);
        n_tests++;
        if ({pc_write, ifid_write} !== 2'b11) begin
            n_fail++;
            $display("FAIL flush_tail_ctrl: got pw/iw=%b%b, want 11", pc_write, ifid_write);
        end
        commit("flush_squash2");
        drive(1'b1, 1'b0, 16'h0044, 16'hCCCC, 16'h0044, 16'hCCCC, 1'b1);
        commit("flush_resume");
    endtask

    task automatic test_flush_over_stall();
        drive(1'b0, 1'b1, 16'h0050, 16'hDDDD, 16'h0050, 16'h0000, 1'b0);
        n_tests++;
        if ({pc_write, ifid_write, bubble} !== 3'b111) begin
            n_fail++;
            $display("FAIL flush_wins_ctrl: got pw/iw/bub=%b%b%b, want 111", pc_write, ifid_write, bubble);
        end
        commit("flush_wins_load");
        drive(1'b0, 1'b0, 16'h0052, 16'hEEEE, 16'h0052, 16'h0000, 1'b0);
        n_tests++;
        if (pc_write !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_wins_state: got pw=%b, want 1", pc_write);
        end
        commit("flush_wins_tail");
        drive(1'b0, 1'b0, 16'h0054, 16'hEEEE, 16'h0052, 16'h0000, 1'b0);
        n_tests++;
        if ({pc_write, bubble} !== 2'b01) begin
            n_fail++;
            $display("FAIL flush_then_stall: got pw/bub=%b%b, want 01", pc_write, bubble);
        end
        commit("flush_then_stall_hold");
        drive(1'b1, 1'b0, 16'h0054, 16'h4321, 16'h0054, 16'h4321, 1'b1);
        commit("flush_then_run");
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 1'b1, 16'h0080, 16'h1111, 16'h0080, 16'h0000, 1'b0);
        commit("b2b_flush1");
        drive(1'b1, 1'b1, 16'h0082, 16'h2222, 16'h0082, 16'h0000, 1'b0);
        commit("b2b_flush2");
        drive(1'b1, 1'b0, 16'h0084, 16'h3333, 16'h0084, 16'h0000, 1'b0);
        commit("b2b_restart_tail");
        drive(1'b1, 1'b0, 16'h0086, 16'h4444, 16'h0086, 16'h4444, 1'b1);
        commit("b2b_resume");
    endtask

    task automatic test_reset_mid_stall();
        drive(1'b0, 1'b0, 16'h0090, 16'h9999, 16'h0086, 16'h4444, 1'b1);
        commit("rst_stall1");
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock); #1;
        n_tests++;
        if ({pc_out, inst_out, valid_out, stall_count, flush_count} !== {16'h0, 16'h0, 1'b0, 8'd0, 8'd0}) begin
            n_fail++;
            $display("FAIL reset_mid_stall: got pc=%h inst=%h v=%b sc=%0d fc=%0d, want 0/0/0/0/0",
                     pc_out, inst_out, valid_out, stall_count, flush_count);
        end
        @(negedge clock);
        reset = 1'b0;
        #1;
        n_tests++;
        if ({pc_write, bubble} !== 2'b01) begin
            n_fail++;
            $display("FAIL reset_then_stall_ctrl: got pw/bub=%b%b, want 01", pc_write, bubble);
        end
        drive(1'b1, 1'b0, 16'h0060, 16'h6060, 16'h0060, 16'h6060, 1'b1);
        commit("reset_back_to_run");
    endtask

    task automatic test_counters();
        logic [7:0] exp_sc;
        logic [7:0] exp_fc;
`ifdef HAZARD_PERF_COUNTERS_EN
        exp_sc = 8'd255;
        exp_fc = 8'd3;
`else
        exp_sc = 8'd0;
        exp_fc = 8'd0;
`endif
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        drive(1'b1, 1'b0, 16'h0070, 16'h7777, 16'h0070, 16'h7777, 1'b1);
        commit("cnt_prime");
        for (int i = 0; i < 300; i++) begin
            drive(1'b0, 1'b0, 16'h0072, 16'h7272, 16'h0070, 16'h7777, 1'b1);
            commit("cnt_stall_hold");
        end
        n_tests++;
        if (stall_count !== exp_sc) begin
            n_fail++;
            $display("FAIL stall_count_sat: got %0d, want %0d", stall_count, exp_sc);
        end
        drive(1'b1, 1'b1, 16'h00A0, 16'hA0A0, 16'h00A0, 16'h0000, 1'b0);
        commit("cnt_flush1");
        drive(1'b1, 1'b1, 16'h00A2, 16'hA2A2, 16'h00A2, 16'h0000, 1'b0);
        commit("cnt_flush2");
        drive(1'b0, 1'b1, 16'h00A4, 16'hA4A4, 16'h00A4, 16'h0000, 1'b0);
        commit("cnt_flush3");
        n_tests++;
        if ({stall_count, flush_count} !== {exp_sc, exp_fc}) begin
            n_fail++;
            $display("FAIL flush_count: got sc=%0d fc=%0d, want sc=%0d fc=%0d",
                     stall_count, flush_count, exp_sc, exp_fc);
        end
    endtask

    initial begin
        test_reset();
        test_run();
        test_stall();
        test_flush();
        test_flush_over_stall();
        test_back_to_back();
        test_reset_mid_stall();
        test_counters();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ifid_hazard_response_component.md
Name: ifid_hazard_response_component

Overview:
- Consumer end of the hazard detection unit's stall/flush interface.
- Owns the IF/ID pipeline register, gates PC write, and requests ID/EX bubbles.
- Stall requests freeze fetch and insert a bubble downstream.
- Flush requests squash the fetched instruction for a programmable number of cycles while the PC loads the branch target.

Parameters:
- DATA_WIDTH, 16, width of PC and instruction words
- NOP_INST, 16'h0000, instruction word injected on squash
- FLUSH_CYCLES, 1, cycles IF/ID is squashed per flush request (1..7)

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- stall  input  1  active-low stall request from hazard unit (0 = stall, 1 = run)
- flush  input  1  active-high branch-taken flush request
- pc_in  input  DATA_WIDTH  PC of the instruction being fetched
- inst_in  input  DATA_WIDTH  fetched instruction
- pc_out  output  DATA_WIDTH  IF/ID registered PC
- inst_out  output  DATA_WIDTH  IF/ID registered instruction
- valid_out  output  1  IF/ID contents are a real instruction
- pc_write  output  1  PC register enable
- ifid_write  output  1  IF/ID load enable (exported for debug)
- bubble  output  1  force ID/EX control signals to zero this cycle
- stall_count  output  8  saturating stall-cycle counter (see Optional Feature)
- flush_count  output  8  saturating flush-event counter (see Optional Feature)

Behaviour:
- Reset values: state=RUN; pc_out=0; inst_out=NOP_INST; valid_out=0; flush counter=0; stall_count=0; flush_count=0.
- Reset dominates all inputs.
- Reset asserted mid-stall or mid-flush returns the block to RUN on the next edge.
- States:
  - RUN: normal fetch.
  - STALL: holding.
  - FLUSH: squashing; carries a 3-bit remaining-cycle counter.
- Priority each cycle: reset > flush > stall > run.
- flush=1 in any state:
  - Next state is FLUSH; remaining counter = FLUSH_CYCLES-1.
  - IF/ID loads pc_in and NOP_INST with valid_out=0.
  - pc_write=1, ifid_write=1, bubble=1.
- FLUSH with counter>0 and flush=0: squash again (NOP, valid_out=0) and decrement the counter. The stall input is ignored while flushing.
- FLUSH with counter==0 and flush=0: behave as RUN or STALL according to the stall input this cycle.
- stall=0 (not flushing):
  - Next state is STALL; pc_write=0, ifid_write=0, bubble=1.
  - IF/ID holds its value, including valid_out.
- stall=1 (not flushing):
  - Next state is RUN; pc_write=1, ifid_write=1, bubble=0.
  - IF/ID loads pc_in and inst_in with valid_out=1.
- Timing:
  - pc_write, ifid_write and bubble are combinational from the current state and inputs.
  - The IF/ID register updates on the rising edge with zero added latency.
- A back-to-back flush while in FLUSH restarts the counter at FLUSH_CYCLES-1.
- A stall that persists for N cycles holds IF/ID for exactly N cycles and asserts bubble for N cycles.
- FLUSH_CYCLES=0 is illegal; it is checked by an elaboration-time assertion.

Optional Feature:
- Macro: HAZARD_PERF_COUNTERS_EN.
- With the macro defined:
  - stall_count increments on every cycle with bubble=1 due to stall.
  - flush_count increments on every cycle where flush=1.
  - Both counters are 8-bit, saturate at 255, and clear on reset.
- Without the macro: both ports remain present and are driven constant 0, and no counter logic is generated.

Decomposition:
- Shared package pipeline_ctrl_pkg contains:
  - state enum {RUN, STALL, FLUSH};
  - NOP_INST default;
  - opcode constants, including BRANCH_OP=4'b1011 shared with the hazard unit;
  - STALL_ACTIVE=1'b0 polarity constant.
- Sub-module sat_counter_component: an 8-bit saturating counter with enable and synchronous clear, instantiated twice under the macro.

Test Plan:
1. Reset, then stall=1, flush=0, pc_in=0x0010, inst_in=0x1234 -> next edge pc_out=0x0010, inst_out=0x1234, valid_out=1, pc_write=1, bubble=0.
2. From state 1, hold stall=0 for 3 cycles with pc_in=0x0012 -> pc_out stays 0x0010 for 3 cycles; pc_write=0 and bubble=1 for 3 cycles; 4th cycle with stall=1 loads 0x0012.
3. FLUSH_CYCLES=2: flush=1 for 1 cycle with pc_in=0x0040 -> two cycles with inst_out=0x0000 and valid_out=0, pc_write=1 throughout; third cycle loads the real instruction.
4. flush=1 and stall=0 simultaneously -> flush wins: NOP loaded, pc_write=1, state FLUSH.
5. Assert reset during the 2nd stall cycle -> next edge valid_out=0, inst_out=0x0000, state RUN, counters 0.
6. With HAZARD_PERF_COUNTERS_EN, hold stall=0 for 300 cycles -> stall_count saturates at 255; without the macro, stall_count stays 0.
